data_recv: RTL
==============

Name: data_recv

Overview:
- Receive-side counterpart of the team's byte transmitter.
- Consumes the transmitter's byte stream and removes escape stuffing: ESC ESC becomes a literal ESC, and ESC c becomes control symbol c.
- Regenerates the ordinary/control flag (byt_o) for each recovered symbol and tracks frame boundaries and frame length.
- Sits between the link data path and the downstream byte consumer.

Parameters:
- ESC, 8'h78, escape byte (ASCII 'x').
- EOF_SYM, 8'h0A, control symbol that closes a frame.
- LEN_W, 8, width of the frame length counter.
- TMO_CYC, 16, escape timeout in cycles; used only with RECV_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- data_in  in  8  received byte.
- data_en  in  1  data_in valid this cycle.
- data_o  out  8  recovered byte or control symbol.
- data_vld  out  1  data_o/byt_o valid, 1-cycle pulse per symbol.
- byt_o  out  1  1 = ordinary data byte, 0 = control symbol.
- frame_end  out  1  1-cycle pulse coincident with EOF_SYM output.
- frame_len  out  LEN_W  data-byte count of the closed frame; held until the next frame_end.
- err  out  1  1-cycle pulse on protocol error.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; length counter 0.
- Reset mid-operation: immediate return to IDLE; a pending escape is discarded with no output.
- Input gating: bytes are accepted only when data_en=1. data_en=0 cycles hold state and counter and produce no output; gaps are legal in any state.
- Latency: every output is registered, 1 cycle after the accepting edge of the byte that completes a symbol.
- FSM state IDLE (outside a frame):
  - non-ESC byte -> output data (byt_o=1), cnt=1, go DATA.
  - ESC -> go ESC_P.
- FSM state DATA:
  - non-ESC byte -> output data (byt_o=1), cnt+1.
  - ESC -> go ESC_P, no output.
- FSM state ESC_P (one escape seen):
  - ESC -> output ESC with byt_o=1, cnt+1, go DATA.
  - EOF_SYM -> output EOF_SYM with byt_o=0, pulse frame_end, frame_len<=cnt, cnt<=0, go IDLE.
  - any other c -> output c with byt_o=0, cnt unchanged, go DATA.
- Control symbols never count toward frame_len.
- Length counter:
  - Saturates at 2^LEN_W-1.
  - The increment that would wrap instead pulses err once and sets a sticky overflow flag.
  - The flag clears at frame_end.
- frame_end and err arriving on the same edge: both pulse; frame_len loads the saturated value.
- An empty frame (ESC EOF_SYM straight from IDLE) gives frame_len=0 with frame_end=1.

Optional Feature:
- Macro: RECV_TIMEOUT_EN.
- Defined: a cycle counter runs while in ESC_P with data_en=0. When it reaches TMO_CYC, the block pulses err, drops the escape (no output) and returns to DATA. The counter clears on any accepted byte and on leaving ESC_P.
- Undefined: ESC_P waits indefinitely and err comes only from length overflow. No counter logic is generated.

Decomposition:
- Shared package data_link_pkg holds:
  - state encoding: IDLE=2'b00, DATA=2'b01, ESC_P=2'b10.
  - ESC and EOF_SYM default constants, shared with the transmitter.
- Optional sub-module len_cnt: saturating counter with clear, load-out and overflow pulse. The rest stays flat in data_recv.

Test Plan:
- Plain stream: 8'h41, 8'h42, ESC, 8'h0A with data_en=1 throughout.
  -> data_vld pulses carrying 41/byt1, 42/byt1, 0A/byt0.
  -> frame_end on the third pulse, frame_len=2.
  -> Each output 1 cycle after its completing byte.
- Literal escape: 8'h78, 8'h78, 8'h31, ESC, EOF.
  -> outputs 78/byt1, 31/byt1, 0A/byt0; frame_len=2.
- Control and gaps: ESC, 3 idle cycles, 8'h05, 8'h66, ESC, EOF.
  -> 05/byt0 (not counted), 66/byt1; frame_len=1. No output during the gap.
- Overflow with LEN_W=3: 9 data bytes then ESC, EOF.
  -> err pulses exactly once, on the 8th byte.
  -> frame_end with frame_len=7.
- Reset mid-escape: ESC, then reset_n low for 1 cycle, then 8'h0A.
  -> no output during reset.
  -> after reset, 0A/byt1 is output as data; state is DATA.
- RECV_TIMEOUT_EN with TMO_CYC=4: ESC, then 4 idle cycles.
  -> err pulses, no data_vld.
  -> the next byte 8'h78 re-enters ESC_P.

Source files
------------

// File: rtl/data_link_pkg.sv
// ---------------------------------------------------------------------------
// data_link_pkg
//
// Definitions shared by the byte transmitter and the byte receiver of the
// data link.
//   - link_state_e : receiver FSM state encoding (IDLE / DATA / ESC_P)
//   - ESC_DEF      : default escape byte (ASCII 'x')
//   - EOF_SYM_DEF  : default control symbol that closes a frame
//   - LEN_W_DEF    : default width of the frame length counter
//   - TMO_CYC_DEF  : default escape timeout, only used by receivers built
//                    with RECV_TIMEOUT_EN
// ---------------------------------------------------------------------------
package data_link_pkg;

    // Receiver states. The fourth code (2'b11) is unused and is treated as
    // an illegal state that recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DATA  = 2'b01,
        ESC_P = 2'b10
    } link_state_e;

    // Escape byte and frame terminator agreed with the transmitter.
    localparam logic [7:0] ESC_DEF     = 8'h78;
    localparam logic [7:0] EOF_SYM_DEF = 8'h0A;

    // Counter sizing defaults.
    localparam int LEN_W_DEF   = 8;
    localparam int TMO_CYC_DEF = 16;

endpackage : data_link_pkg

// File: rtl/data_recv_len_cnt.sv
// ---------------------------------------------------------------------------
// len_cnt
//
// Saturating frame length counter for the data link receiver.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous reset, active low
//   i_inc    in   count one more data byte in the current frame
//   i_close  in   frame closes: copy the count to o_len, clear the count
//                 and the overflow flag
//   o_len    out  length of the last closed frame, held until next close
//   o_ovf    out  one-cycle pulse on the first increment that would wrap
// ---------------------------------------------------------------------------
module len_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_close,
    output logic [LEN_W-1:0] o_len,
    output logic             o_ovf
);

    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf_flag;
    logic             r_ovf;

    // The running count stops at all-ones. The first increment attempted at
    // that value raises a single overflow pulse; the sticky flag keeps the
    // remaining bytes of the same frame from pulsing again. Closing a frame
    // has priority, so a frame that overflowed reports the saturated count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_ovf_flag <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (i_close) begin
                r_len      <= r_cnt;
                r_cnt      <= '0;
                r_ovf_flag <= 1'b0;
            end else if (i_inc) begin
                if (r_cnt != {LEN_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!r_ovf_flag) begin
                    r_ovf_flag <= 1'b1;
                    r_ovf      <= 1'b1;
                end
            end
        end
    end

    assign o_len = r_len;
    assign o_ovf = r_ovf;

endmodule : len_cnt

// File: rtl/data_recv.sv
// ---------------------------------------------------------------------------
// data_recv
//
// Receive side of the byte link. Removes the transmitter's escape stuffing:
// ESC ESC yields a literal ESC data byte, ESC c yields control symbol c.
// Every recovered symbol is presented for one cycle with a flag telling data
// bytes from control symbols. ESC EOF_SYM closes a frame and reports the
// number of data bytes it carried.
//
// Optional feature (macro RECV_TIMEOUT_EN): an escape left pending for
// TMO_CYC idle cycles is dropped with an err pulse and the receiver falls
// back to DATA. Without the macro the escape waits indefinitely.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous reset, active low
//   data_in    in   received byte
//   data_en    in   data_in is valid this cycle
//   data_o     out  recovered data byte or control symbol
//   data_vld   out  data_o / byt_o valid, one pulse per symbol
//   byt_o      out  1 = ordinary data byte, 0 = control symbol
//   frame_end  out  pulse together with the EOF_SYM output
//   frame_len  out  data byte count of the last closed frame (held)
//   err        out  pulse on length overflow (or escape timeout)
// ---------------------------------------------------------------------------
module data_recv
    import data_link_pkg::*;
#(
    parameter logic [7:0] ESC     = ESC_DEF,
    parameter logic [7:0] EOF_SYM = EOF_SYM_DEF,
`ifdef RECV_TIMEOUT_EN
    parameter int         TMO_CYC = TMO_CYC_DEF,
`endif
    parameter int         LEN_W   = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       data_in,
    input  logic             data_en,
    output logic [7:0]       data_o,
    output logic             data_vld,
    output logic             byt_o,
    output logic             frame_end,
    output logic [LEN_W-1:0] frame_len,
    output logic             err
);

    link_state_e r_state;
    link_state_e w_state_nxt;

    logic        w_sym_vld;
    logic        w_sym_byt;
    logic        w_sym_eof;
    logic        w_len_inc;
    logic        w_len_close;
    logic        w_len_ovf;

    logic [7:0]  r_data;
    logic        r_vld;
    logic        r_byt;
    logic        r_eof;

`ifdef RECV_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_hit;
    logic             r_tmo_err;

    // The timeout fires on the idle cycle that would bring the count to
    // TMO_CYC, so exactly TMO_CYC idle cycles in ESC_P drop the escape.
    assign w_tmo_hit = (r_state == ESC_P) && !data_en && (r_tmo_cnt == TMO_LAST);

    // Idle-cycle counter for a pending escape. Any accepted byte, the
    // timeout itself, or being in another state returns it to zero, so each
    // new escape starts from a fresh count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_tmo_hit;
            if ((r_state != ESC_P) || data_en || w_tmo_hit) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end
`endif

    // FSM state register. Reset drops any pending escape on the spot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and symbol decode. IDLE and DATA react identically to a
    // byte; they differ only in that IDLE means no frame is open, which the
    // length counter already reflects by sitting at zero. After an escape
    // every byte produces a symbol: ESC is a counted data byte, everything
    // else is an uncounted control symbol, and EOF_SYM also closes the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_sym_vld   = 1'b0;
        w_sym_byt   = 1'b1;
        w_sym_eof   = 1'b0;
        w_len_inc   = 1'b0;
        w_len_close = 1'b0;
        case (r_state)
            IDLE, DATA: begin
                if (data_en) begin
                    if (data_in == ESC) begin
                        w_state_nxt = ESC_P;
                    end else begin
                        w_sym_vld   = 1'b1;
                        w_len_inc   = 1'b1;
                        w_state_nxt = DATA;
                    end
                end
            end
            ESC_P: begin
                if (data_en) begin
                    w_sym_vld   = 1'b1;
                    w_state_nxt = DATA;
                    if (data_in == ESC) begin
                        w_len_inc = 1'b1;
                    end else if (data_in == EOF_SYM) begin
                        w_sym_byt   = 1'b0;
                        w_sym_eof   = 1'b1;
                        w_len_close = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_sym_byt = 1'b0;
                    end
                end
`ifdef RECV_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = DATA;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Symbol output registers. data_o and byt_o only change when a symbol
    // is produced, so they stay stable between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            r_byt  <= 1'b0;
            r_eof  <= 1'b0;
        end else begin
            r_vld <= w_sym_vld;
            r_eof <= w_sym_eof;
            if (w_sym_vld) begin
                r_data <= data_in;
                r_byt  <= w_sym_byt;
            end
        end
    end

    len_cnt #(
        .LEN_W (LEN_W)
    ) u_len_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_len_inc),
        .i_close (w_len_close),
        .o_len   (frame_len),
        .o_ovf   (w_len_ovf)
    );

    assign data_o    = r_data;
    assign data_vld  = r_vld;
    assign byt_o     = r_byt;
    assign frame_end = r_eof;

`ifdef RECV_TIMEOUT_EN
    assign err = w_len_ovf | r_tmo_err;
`else
    assign err = w_len_ovf;
`endif

endmodule : data_recv
